// File: rtl/solve_sequencer.sv
// solve_sequencer: run controller for the nonogram pipeline.
// Sequences parse -> solve -> emit, or reports a one-byte error code.
module solve_sequencer #(
    parameter int          TIMEOUT_CYCLES = 100_000_000,
    parameter int          CNT_W          = 27,
    parameter logic [7:0]  ERR_PARSE      = 8'hE3,
    parameter logic [7:0]  ERR_UNSAT      = 8'hE1,
    parameter logic [7:0]  ERR_TIMEOUT    = 8'hE2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       parse_done,
    input  logic       parse_error,
    input  logic [3:0] n_in,
    input  logic [3:0] m_in,
    output logic       solver_start,
    input  logic       solver_done,
    input  logic       solver_unsat,
    output logic       asm_valid,
    input  logic       asm_done,
    input  logic       transmit_busy,
    output logic       err_ready,
    output logic [7:0] err_byte,
    output logic       tx_sel,
    output logic [3:0] n,
    output logic [3:0] m,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SOLVE  = 3'd2,
        EMIT   = 3'd3,
        ERR    = 3'd4,
        ERR_TX = 3'd5
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       err_n;
    logic [3:0]       n_n;
    logic [3:0]       m_n;
    logic [CNT_W-1:0] wd;
    logic             size_ok;
    logic             expired;

    assign size_ok = (n_in != 4'd0) && (n_in <= 4'd11) &&
                     (m_in != 4'd0) && (m_in <= 4'd11);
    assign expired = (wd == CNT_W'(TIMEOUT_CYCLES - 1));
    assign state_dbg = state;

    // Next-state, next error code and next board size.
    always_comb begin
        state_n = state;
        err_n   = err_byte;
        n_n     = n;
        m_n     = m;
        unique case (state)
            IDLE: begin
                if (parse_error) begin
                    err_n   = ERR_PARSE;
                    state_n = ERR;
                end else if (parse_done) begin
                    if (size_ok) begin
                        n_n     = n_in;
                        m_n     = m_in;
                        state_n = START;
                    end else begin
                        err_n   = ERR_PARSE;
                        state_n = ERR;
                    end
                end
            end
            START: state_n = SOLVE;
            SOLVE: begin
                if (solver_unsat) begin
                    err_n   = ERR_UNSAT;
                    state_n = ERR;
                end else if (solver_done) begin
                    state_n = EMIT;
                end else if (expired) begin
                    err_n   = ERR_TIMEOUT;
                    state_n = ERR;
                end
            end
            EMIT: begin
                if (asm_done) state_n = IDLE;
            end
            ERR: begin
                if (!transmit_busy) state_n = ERR_TX;
            end
            ERR_TX: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, derived from the transition taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            err_byte     <= 8'd0;
            n            <= 4'd0;
            m            <= 4'd0;
            solver_start <= 1'b0;
            asm_valid    <= 1'b0;
            err_ready    <= 1'b0;
            tx_sel       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            err_byte     <= err_n;
            n            <= n_n;
            m            <= m_n;
            solver_start <= (state_n == START);
            asm_valid    <= (state == SOLVE) && (state_n == EMIT);
            err_ready    <= (state == ERR) && (state_n == ERR_TX);
            tx_sel       <= (state_n == ERR) || (state_n == ERR_TX);
            busy         <= (state_n != IDLE);
        end
    end

    // Solver watchdog: cleared in START, counts through SOLVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (state == START) begin
            wd <= '0;
        end else if (state == SOLVE) begin
            wd <= wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_solve_sequencer.sv
// tb_solve_sequencer: directed and randomized puzzle runs for solve_sequencer.
// Expected behaviour is derived per puzzle from the outcome rules.
module tb_solve_sequencer;

    localparam int T = 20;
    localparam logic [31:0] E_PARSE = 32'hE3;
    localparam logic [31:0] E_UNSAT = 32'hE1;
    localparam logic [31:0] E_TMO   = 32'hE2;
    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_START = 32'd1;
    localparam logic [31:0] S_SOLVE = 32'd2;
    localparam logic [31:0] S_EMIT  = 32'd3;
    localparam logic [31:0] S_ERR   = 32'd4;
    localparam logic [31:0] S_ERRTX = 32'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       parse_done, parse_error;
    logic [3:0] n_in, m_in;
    logic       solver_start, solver_done, solver_unsat;
    logic       asm_valid, asm_done, transmit_busy;
    logic       err_ready, tx_sel, busy;
    logic [7:0] err_byte;
    logic [3:0] n, m;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    logic [31:0] exp_n = 0;
    logic [31:0] exp_m = 0;
    logic [31:0] exp_err = 0;

    solve_sequencer #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .parse_done(parse_done),
        .parse_error(parse_error),
        .n_in(n_in),
        .m_in(m_in),
        .solver_start(solver_start),
        .solver_done(solver_done),
        .solver_unsat(solver_unsat),
        .asm_valid(asm_valid),
        .asm_done(asm_done),
        .transmit_busy(transmit_busy),
        .err_ready(err_ready),
        .err_byte(err_byte),
        .tx_sel(tx_sel),
        .n(n),
        .m(m),
        .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        parse_done   = 1'b0;
        parse_error  = 1'b0;
        solver_done  = 1'b0;
        solver_unsat = 1'b0;
        asm_done     = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state_dbg), S_IDLE);
        chk({tag, "_n"}, 32'(n), 0);
        chk({tag, "_m"}, 32'(m), 0);
        chk({tag, "_err_byte"}, 32'(err_byte), 0);
        chk({tag, "_tx_sel"}, 32'(tx_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_solver_start"}, 32'(solver_start), 0);
        chk({tag, "_asm_valid"}, 32'(asm_valid), 0);
        chk({tag, "_err_ready"}, 32'(err_ready), 0);
    endtask

    // Error reporting: b busy cycles, then err_ready, then back to idle.
    task automatic err_phase(input int b);
        chk("err_state", 32'(state_dbg), S_ERR);
        chk("err_tx_sel", 32'(tx_sel), 1);
        chk("err_byte", 32'(err_byte), exp_err);
        chk("err_ready_low", 32'(err_ready), 0);
        for (int i = 0; i <= b; i++) begin
            transmit_busy = (i < b);
            if (i == 0) begin
                solver_done = 1'b1;
                parse_done  = 1'b1;
                n_in        = 4'd7;
                m_in        = 4'd7;
            end
            tick();
            if (i < b) begin
                chk("err_wait_state", 32'(state_dbg), S_ERR);
                chk("err_wait_ready", 32'(err_ready), 0);
                chk("err_wait_asm", 32'(asm_valid), 0);
            end
        end
        chk("errtx_state", 32'(state_dbg), S_ERRTX);
        chk("errtx_ready", 32'(err_ready), 1);
        chk("errtx_tx_sel", 32'(tx_sel), 1);
        chk("errtx_byte", 32'(err_byte), exp_err);
        transmit_busy = 1'b1;
        tick();
        transmit_busy = 1'b0;
        chk("post_err_state", 32'(state_dbg), S_IDLE);
        chk("post_err_ready", 32'(err_ready), 0);
        chk("post_err_tx_sel", 32'(tx_sel), 0);
        chk("post_err_busy", 32'(busy), 0);
        chk("post_err_byte", 32'(err_byte), exp_err);
        chk("post_err_n", 32'(n), exp_n);
    endtask

    // One puzzle: response at SOLVE cycle d (done=rd, unsat=ru),
    // assembler finishes after a cycles, transmitter busy for b cycles.
    task automatic run_puzzle(input logic [3:0] ni, input logic [3:0] mi,
                              input bit perr, input int d, input bit rd,
                              input bit ru, input int a, input int b);
        bit ok;
        bit resp;
        int last;
        int unsigned s;
        ok = !perr && ni >= 1 && ni <= 11 && mi >= 1 && mi <= 11;
        resp = (rd || ru) && d < T;
        last = resp ? d : T - 1;
        parse_done  = 1'b1;
        parse_error = perr;
        n_in = ni;
        m_in = mi;
        tick();
        if (!ok) begin
            exp_err = E_PARSE;
            chk("parse_no_start", 32'(solver_start), 0);
            chk("parse_busy", 32'(busy), 1);
            err_phase(b);
            return;
        end
        exp_n = 32'(ni);
        exp_m = 32'(mi);
        s = cyc;
        chk("start_pulse", 32'(solver_start), 1);
        chk("start_state", 32'(state_dbg), S_START);
        chk("start_busy", 32'(busy), 1);
        chk("start_n", 32'(n), exp_n);
        chk("start_m", 32'(m), exp_m);
        tick();
        for (int j = 0; j <= last; j++) begin
            chk("solve_state", 32'(state_dbg), S_SOLVE);
            chk("solve_start_low", 32'(solver_start), 0);
            chk("solve_asm_low", 32'(asm_valid), 0);
            parse_done  = ($urandom % 3 == 0);
            parse_error = ($urandom % 5 == 0);
            asm_done    = ($urandom % 3 == 0);
            n_in = 4'($urandom);
            m_in = 4'($urandom);
            if (resp && j == d) begin
                solver_done  = rd;
                solver_unsat = ru;
            end
            tick();
        end
        if (resp && !ru) begin
            chk("emit_state", 32'(state_dbg), S_EMIT);
            chk("emit_asm_valid", 32'(asm_valid), 1);
            chk("emit_tx_sel", 32'(tx_sel), 0);
            for (int i = 0; i <= a; i++) begin
                if (i > 0) begin
                    chk("emit_hold_state", 32'(state_dbg), S_EMIT);
                    chk("emit_asm_once", 32'(asm_valid), 0);
                end
                solver_done  = ($urandom % 2 == 0);
                solver_unsat = ($urandom % 3 == 0);
                parse_done   = ($urandom % 3 == 0);
                n_in = 4'($urandom);
                asm_done = (i == a);
                tick();
            end
            chk("done_state", 32'(state_dbg), S_IDLE);
            chk("done_busy", 32'(busy), 0);
            chk("done_asm_low", 32'(asm_valid), 0);
            chk("done_n_held", 32'(n), exp_n);
            chk("done_m_held", 32'(m), exp_m);
            chk("done_err_held", 32'(err_byte), exp_err);
        end else begin
            exp_err = ru && resp ? E_UNSAT : E_TMO;
            if (!resp)
                chk("timeout_latency", cyc - s, 32'(T + 1));
            chk("solve_err_asm", 32'(asm_valid), 0);
            err_phase(b);
        end
    endtask

    initial begin
        rst = 1'b1;
        parse_done = 0; parse_error = 0; n_in = 0; m_in = 0;
        solver_done = 0; solver_unsat = 0; asm_done = 0;
        transmit_busy = 0;
        #1;
        chk_reset_vals("por");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("after_rst");

        run_puzzle(4'd4, 4'd4, 0, 3, 1, 0, 2, 0);
        run_puzzle(4'd12, 4'd4, 0, 0, 1, 0, 0, 3);
        run_puzzle(4'd5, 4'd5, 0, 2, 0, 1, 0, 50);
        run_puzzle(4'd3, 4'd3, 0, 99, 0, 0, 0, 2);
        run_puzzle(4'd6, 4'd7, 0, 1, 1, 1, 0, 1);
        run_puzzle(4'd2, 4'd9, 0, T - 1, 1, 0, 1, 0);
        run_puzzle(4'd4, 4'd4, 1, 0, 1, 0, 0, 0);
        run_puzzle(4'd1, 4'd1, 0, 0, 1, 0, 0, 0);
        run_puzzle(4'd11, 4'd11, 0, 5, 1, 0, 3, 0);
        run_puzzle(4'd0, 4'd5, 0, 0, 1, 0, 0, 1);
        run_puzzle(4'd5, 4'd0, 0, 0, 1, 0, 0, 0);
        run_puzzle(4'd11, 4'd12, 0, 0, 1, 0, 0, 0);
        run_puzzle(4'd15, 4'd15, 0, 0, 1, 0, 0, 0);

        // Reset in the middle of SOLVE.
        parse_done = 1; n_in = 4'd5; m_in = 4'd6;
        tick();
        tick();
        tick();
        chk("pre_rst_solve", 32'(state_dbg), S_SOLVE);
        rst = 1'b1;
        #1;
        exp_n = 0; exp_m = 0; exp_err = 0;
        chk_reset_vals("rst_solve");
        solver_done = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_solve_held");
        solver_done = 1'b0;
        rst = 1'b0;

        // Reset in the middle of EMIT.
        parse_done = 1; n_in = 4'd8; m_in = 4'd3;
        tick();
        tick();
        solver_done = 1'b1;
        tick();
        chk("pre_rst_emit", 32'(state_dbg), S_EMIT);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_emit");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_puzzle(4'd7, 4'd9, 0, 4, 1, 0, 2, 0);

        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            run_puzzle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       ($urandom % 8 == 0), $urandom_range(0, T + 3),
                       sel[0], sel[1], $urandom_range(0, 4),
                       $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
